// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC transmitter/checker pair.
// Both ends use lfsr_step so the polynomial can only change in one place.
package crc_pkg;

  localparam int                    CRC_WIDTH = 8;
  localparam logic [CRC_WIDTH-1:0]  CRC_TAPS  = 8'b0100_0100;
  localparam logic [CRC_WIDTH-1:0]  CRC_SEED  = 8'hD8;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_e;

  // Right-shifting Galois LFSR: feedback enters the MSB and is folded into tapped bits.
  function automatic logic [CRC_WIDTH-1:0] lfsr_step(input logic [CRC_WIDTH-1:0] l,
                                                     input logic                 d);
    logic fb;
    fb = d ^ l[0];
    return {fb, l[CRC_WIDTH-1:1]} ^ ({1'b0, CRC_TAPS[CRC_WIDTH-2:0]} & {CRC_WIDTH{fb}});
  endfunction

endpackage

// File: rtl/crc_if.sv
// Serial link between CRC transmitter (master) and CRC checker (slave).
interface crc_if;
  logic data_in;
  logic active;
  logic crc_valid;
  logic busy;
  logic done;
  logic crc_ok;
  logic crc_err;

  modport master (output data_in, active, crc_valid,
                  input  busy, done, crc_ok, crc_err);
  modport slave  (input  data_in, active, crc_valid,
                  output busy, done, crc_ok, crc_err);
endinterface

// File: rtl/crc_lfsr.sv
// CRC LFSR register: load-and-step from SEED, step, or zero-fill shift-out.
// load takes priority over step, which takes priority over shift.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int               WIDTH = CRC_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS,
  parameter logic [WIDTH-1:0] SEED  = CRC_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             shift,
  input  logic             d,
  output logic [WIDTH-1:0] lfsr
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d, base;
  logic             fb;

  always_comb begin
    base   = load ? SEED : lfsr_q;
    fb     = d ^ base[0];
    lfsr_d = lfsr_q;
    if (load || step)
      lfsr_d = {fb, base[WIDTH-1:1]} ^ ({1'b0, TAPS[WIDTH-2:0]} & {WIDTH{fb}});
    else if (shift)
      lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/crc_checker.sv
// Serial CRC checker: runs the LFSR over data bits, then compares the received
// CRC (LSB first) bit by bit and reports a registered pass/fail with a done pulse.
module crc_checker
  import crc_pkg::*;
#(
  parameter int               WIDTH = CRC_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS,
  parameter logic [WIDTH-1:0] SEED  = CRC_SEED
) (
  input  logic  clk,
  input  logic  rst,
  crc_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d, cnt_inc;
  logic             mismatch_q, mismatch_d, mm_inc;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             ld, stp, shf;
  logic [WIDTH-1:0] lfsr;

  crc_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (ld),
    .step  (stp),
    .shift (shf),
    .d     (bus.data_in),
    .lfsr  (lfsr)
  );

  // Outcome of taking the current bit as a CRC bit; the first CRC bit arrives in DATA.
  always_comb begin
    mm_inc  = (bus.data_in != lfsr[0]) | ((state_q == CHECK) & mismatch_q);
    cnt_inc = ((state_q == CHECK) ? bit_cnt_q : '0) + CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    mismatch_d = mismatch_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;
    ld         = 1'b0;
    stp        = 1'b0;
    shf        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.active) begin
          ld         = 1'b1;
          mismatch_d = 1'b0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bus.active) begin
          stp = 1'b1;
        end else if (bus.crc_valid) begin
          shf = 1'b1;
          if (cnt_inc == LAST) begin
            done_d    = 1'b1;
            ok_d      = !mm_inc;
            err_d     = mm_inc;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            mismatch_d = mm_inc;
            bit_cnt_d  = cnt_inc;
            state_d    = CHECK;
          end
        end
      end
      CHECK: begin
        if (bus.active) begin
          // New frame preempts the one being checked: fail it and restart from SEED.
          done_d     = 1'b1;
          ok_d       = 1'b0;
          err_d      = 1'b1;
          ld         = 1'b1;
          mismatch_d = 1'b0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end else if (bus.crc_valid) begin
          shf = 1'b1;
          if (cnt_inc == LAST) begin
            done_d    = 1'b1;
            ok_d      = !mm_inc;
            err_d     = mm_inc;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            mismatch_d = mm_inc;
            bit_cnt_d  = cnt_inc;
          end
        end else begin
          done_d    = 1'b1;
          ok_d      = 1'b0;
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.crc_ok  = ok_q;
  assign bus.crc_err = err_q;

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
Serial CRC receiver/checker. It is the far end of the team's serial CRC transmitter, which sends data bits while `active` is high and then shifts out WIDTH CRC bits (LSB first) while `valid` is high.
The block runs the same LFSR over the received data bits, then compares the received CRC bits one by one against its own LFSR contents. At end of frame it reports pass or fail with a single-cycle `done` pulse.

Parameters:
- WIDTH, 8: CRC/LFSR width in bits.
- TAPS, 8'b0100_0100: XOR tap mask over LFSR bits [WIDTH-2:0].
- SEED, 8'hD8: LFSR value loaded at the start of each frame.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  1  serial bit; a data bit when `active`=1, a CRC bit when `crc_valid`=1.
- active  in  1  data-phase qualifier.
- crc_valid  in  1  CRC-phase qualifier; the CRC arrives LSB first.
- busy  out  1  high while a frame is in progress (state != IDLE).
- done  out  1  one-cycle pulse when a frame ends.
- crc_ok  out  1  sticky pass flag; updated only when `done` fires.
- crc_err  out  1  sticky fail flag; updated only when `done` fires; never high together with `crc_ok`.

Behaviour:
- Reset:
  - Asynchronous; state=IDLE.
  - lfsr=SEED, bit_cnt=0, mismatch=0.
  - busy=0, done=0, crc_ok=0, crc_err=0.
- LFSR step, step(l,d):
  - fb = d ^ l[0].
  - new[WIDTH-1] = fb.
  - For i < WIDTH-1: new[i] = l[i+1] ^ (TAPS[i] & fb).
- States: IDLE, DATA, CHECK.
- IDLE:
  - `active`=1: lfsr <= step(SEED, data_in); go to DATA.
  - `crc_valid` without `active`: ignored; no done.
- DATA:
  - `active`=1: lfsr <= step(lfsr, data_in).
  - `active`=0 and `crc_valid`=0: hold (inter-phase gap of any length allowed; the transmitter inserts one cycle).
  - `crc_valid`=1 and `active`=0: first CRC bit.
    - mismatch <= (data_in != lfsr[0]).
    - lfsr <= lfsr >> 1 (zero fill).
    - bit_cnt <= 1; go to CHECK.
- CHECK, `crc_valid`=1:
  - mismatch |= (data_in != lfsr[0]); shift lfsr; bit_cnt++.
  - When this is bit number WIDTH, in the next cycle:
    - done=1.
    - crc_ok = !final_mismatch; crc_err = final_mismatch.
    - Return to IDLE; bit_cnt=0.
- Latency: `done` goes high exactly 1 cycle after the clock edge that samples the last CRC bit.
- Abort, `crc_valid`=0 in CHECK before WIDTH bits:
  - Next cycle: done=1, crc_err=1, crc_ok=0; go to IDLE.
- `active` and `crc_valid` both high: `active` wins; treated as a data bit (in CHECK this is the new-frame case below).
- New frame, `active`=1 while in CHECK:
  - Current frame aborts: done=1 with crc_err=1 next cycle.
  - Same edge: lfsr <= step(SEED, data_in); go to DATA.
- Back-to-back frames: `active` in the same cycle `done` is high is accepted normally (that cycle's state is IDLE).
- Reset mid-frame: immediate return to reset values; no done.
- bit_cnt width: $clog2(WIDTH+1). It must never wrap within a frame.

Decomposition:
- Shared package `crc_pkg`:
  - constants CRC_WIDTH=8, CRC_TAPS, CRC_SEED;
  - state enum {IDLE, DATA, CHECK};
  - function `lfsr_step(l, d)`, shared with the transmitter so both ends stay identical.
- Optional sub-module `crc_lfsr`:
  - controls: load-seed, step, shift-out;
  - also the natural refactor target for the transmitter.
- The FSM and the bit counter stay in `crc_checker`.

Test Plan:
1. Single data bit 0 (`active` 1 cycle), 1 gap cycle, then CRC 8'h6C LSB first (0,0,1,1,0,1,1,0) with `crc_valid` 8 cycles -> done=1 one cycle after the last bit, crc_ok=1, crc_err=0, busy=0 afterwards.
2. Data bits 0 then 1 -> expected CRC 8'hF2. Send 8'hF2 -> crc_ok=1. Repeat sending 8'hF3 (bit 0 flipped) -> crc_err=1, crc_ok=0.
3. Data bit 1 (CRC 8'hA8). Drop `crc_valid` after 5 CRC bits -> done pulse on the following cycle with crc_err=1; state IDLE.
4. Frame 1 (data 0, CRC 6C) with `active` for frame 2 (data 1, CRC A8) asserted in frame 1's done cycle -> two done pulses, both crc_ok=1.
5. `active` re-asserted during CHECK at CRC bit 3 -> crc_err done pulse; the new frame (data 1, CRC A8) then passes.
6. Assert rst during CHECK -> all outputs 0 asynchronously, no done. `crc_valid` alone in IDLE -> no done, busy stays 0.
